// File: rtl/alu_exe_stage_if.sv
// rtl/alu_exe_stage_if.sv - issue/result bundle between ALU control and the execute stage
//
// Purpose: groups the issue-side inputs (in_*) and the registered result
// outputs (out_*) of the execute stage.
// Ports (as signals):
//   in_valid, in_ctrl[4:0], in_src1/in_src2[XLEN], in_rd[4:0], in_wb_en,
//   in_stall, in_flush                       -- driven by the issuing side
//   out_valid, out_result[XLEN], out_rd[4:0], out_wb_en, out_br_taken,
//   out_illegal                              -- driven by the execute stage
// Modports: master = issuing side, slave = execute stage.
interface alu_exe_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [4:0]      in_ctrl;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic [4:0]      in_rd;
    logic            in_wb_en;
    logic            in_stall;
    logic            in_flush;

    logic            out_valid;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_wb_en;
    logic            out_br_taken;
    logic            out_illegal;

    modport master (
        output in_valid, in_ctrl, in_src1, in_src2, in_rd, in_wb_en, in_stall, in_flush,
        input  out_valid, out_result, out_rd, out_wb_en, out_br_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_ctrl, in_src1, in_src2, in_rd, in_wb_en, in_stall, in_flush,
        output out_valid, out_result, out_rd, out_wb_en, out_br_taken, out_illegal
    );
endinterface

// File: rtl/alu_exe_stage.sv
// rtl/alu_exe_stage.sv - single-cycle ALU execute stage with registered outputs
//
// Purpose: computes ALU/branch/JALR results from the issued operands and
// captures them into an output register; stall holds, flush inserts a bubble.
// Ports:
//   clk    -- clock, all state on rising edge
//   rst_n  -- synchronous active-low reset
//   bus    -- alu_exe_stage_if.slave (in_* issue inputs, out_* registered outputs)
module alu_exe_stage #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exe_stage_if.slave bus
);
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_JALR = 5'd10;
    localparam logic [4:0] OP_BEQ  = 5'd11;
    localparam logic [4:0] OP_BNE  = 5'd12;
    localparam logic [4:0] OP_BLT  = 5'd13;
    localparam logic [4:0] OP_BGE  = 5'd14;
    localparam logic [4:0] OP_BLTU = 5'd15;
    localparam logic [4:0] OP_BGEU = 5'd16;
    localparam logic [4:0] OP_IMM  = 5'd17;

    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      shamt;
    logic [XLEN-1:0] sum;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] res;
    logic            br;
    logic            illegal;
    logic            live;

    assign src1  = bus.in_src1;
    assign src2  = bus.in_src2;
    assign shamt = src2[4:0];
    assign sum   = src1 + src2;
    assign eq    = (src1 == src2);
    assign lt_s  = ($signed(src1) < $signed(src2));
    assign lt_u  = (src1 < src2);
    // A slot only carries side effects when it is valid and not being killed.
    assign live  = bus.in_valid & ~bus.in_flush;

    always_comb begin
        res     = '0;
        br      = 1'b0;
        illegal = 1'b0;
        case (bus.in_ctrl)
            OP_ADD:  res = sum;
            OP_SUB:  res = src1 - src2;
            OP_SLL:  res = src1 << shamt;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:  res = src1 ^ src2;
            OP_SRL:  res = src1 >> shamt;
            OP_SRA:  res = $unsigned($signed(src1) >>> shamt);
            OP_OR:   res = src1 | src2;
            OP_AND:  res = src1 & src2;
            OP_JALR: begin
                res = {sum[XLEN-1:1], 1'b0};
                br  = 1'b1;
            end
            OP_BEQ:  br = eq;
            OP_BNE:  br = ~eq;
            OP_BLT:  br = lt_s;
            OP_BGE:  br = ~lt_s;
            OP_BLTU: br = lt_u;
            OP_BGEU: br = ~lt_u;
            OP_IMM:  res = src2;
            default: illegal = 1'b1;
        endcase
    end

    // Flush wins over stall so a killed slot never lingers in the register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_result   <= '0;
            bus.out_rd       <= '0;
            bus.out_wb_en    <= 1'b0;
            bus.out_br_taken <= 1'b0;
            bus.out_illegal  <= 1'b0;
        end else if (bus.in_flush || !bus.in_stall) begin
            bus.out_valid    <= live;
            bus.out_result   <= res;
            bus.out_rd       <= bus.in_rd;
            bus.out_wb_en    <= live & bus.in_wb_en & ~illegal;
            bus.out_br_taken <= live & br;
            bus.out_illegal  <= live & illegal;
        end
    end
endmodule

// File: tb/tb_alu_exe_stage.sv
// tb/tb_alu_exe_stage.sv - self-checking bench for alu_exe_stage
module tb_alu_exe_stage;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exe_stage_if #(.XLEN(XLEN)) bus();

    alu_exe_stage #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
        logic        br;
        logic        ill;
    } out_t;

    out_t exp_q;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] exp_result;
        logic        exp_br;
        logic        exp_ill;
        logic        exp_wb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference ALU using integer arithmetic on 64-bit values.
    function automatic void alu_ref(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic br, output logic ill);
        longint ua, ub, sa, sb, p2, q;
        int sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
        sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
        sh = int'(b[4:0]);
        p2 = 1;
        for (int i = 0; i < sh; i++) p2 = p2 * 2;
        r = '0; br = 1'b0; ill = 1'b0;
        case (c)
            5'd0:  r = 32'(ua + ub);
            5'd1:  r = 32'(ua - ub);
            5'd2:  r = 32'(ua * p2);
            5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = 32'(ua / p2);
            5'd7: begin
                q = (sa >= 0) ? sa / p2 : -((-sa + p2 - 1) / p2);
                r = 32'(q);
            end
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: begin r = 32'(ua + ub) & 32'hFFFF_FFFE; br = 1'b1; end
            5'd11: br = (ua == ub);
            5'd12: br = (ua != ub);
            5'd13: br = (sa < sb);
            5'd14: br = (sa >= sb);
            5'd15: br = (ua < ub);
            5'd16: br = (ua >= ub);
            5'd17: r = b;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic wb, input logic st, input logic fl);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_rd    = rd;
        bus.in_wb_en = wb;
        bus.in_stall = st;
        bus.in_flush = fl;
    endtask

    // Advance one clock, updating the expected register from the current inputs.
    task automatic tick();
        logic [31:0] r;
        logic br, ill, live;
        if (!rst_n) begin
            exp_q = '0;
        end else if (bus.in_flush || !bus.in_stall) begin
            alu_ref(bus.in_ctrl, bus.in_src1, bus.in_src2, r, br, ill);
            live         = bus.in_valid && !bus.in_flush;
            exp_q.valid  = live;
            exp_q.result = r;
            exp_q.rd     = bus.in_rd;
            exp_q.wb_en  = live && bus.in_wb_en && !ill;
            exp_q.br     = live && br;
            exp_q.ill    = live && ill;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},  64'(bus.out_valid),    64'(exp_q.valid));
        check({tag, ".result"}, 64'(bus.out_result),   64'(exp_q.result));
        check({tag, ".rd"},     64'(bus.out_rd),       64'(exp_q.rd));
        check({tag, ".wb_en"},  64'(bus.out_wb_en),    64'(exp_q.wb_en));
        check({tag, ".br"},     64'(bus.out_br_taken), 64'(exp_q.br));
        check({tag, ".ill"},    64'(bus.out_illegal),  64'(exp_q.ill));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},  64'(bus.out_valid),    64'd0);
        check({tag, ".result"}, 64'(bus.out_result),   64'd0);
        check({tag, ".rd"},     64'(bus.out_rd),       64'd0);
        check({tag, ".wb_en"},  64'(bus.out_wb_en),    64'd0);
        check({tag, ".br"},     64'(bus.out_br_taken), 64'd0);
        check({tag, ".ill"},    64'(bus.out_illegal),  64'd0);
    endtask

    initial begin
        vecs.push_back('{"add_wrap",  5'd0,  32'hFFFF_FFFF, 32'h1,        5'd5,  1'b1, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sra",       5'd7,  32'h8000_0000, 32'h24,       5'd6,  1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"srl",       5'd6,  32'h8000_0000, 32'h24,       5'd7,  1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"blt",       5'd13, 32'hFFFF_FFFF, 32'h1,        5'd0,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{"bltu",      5'd15, 32'hFFFF_FFFF, 32'h1,        5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{"bge_eq",    5'd14, 32'h7,         32'h7,        5'd0,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{"jalr",      5'd10, 32'h1001,      32'h4,        5'd1,  1'b1, 32'h1004,     1'b1, 1'b0, 1'b1});
        vecs.push_back('{"illegal20", 5'd20, 32'h1234,      32'h5678,     5'd9,  1'b1, 32'h0,        1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sub_neg",   5'd1,  32'h3,         32'h5,        5'd10, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"slt",       5'd3,  32'hFFFF_FFFF, 32'h1,        5'd11, 1'b1, 32'h1,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sltu",      5'd4,  32'hFFFF_FFFF, 32'h1,        5'd12, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{"imm",       5'd17, 32'h0,         32'hABCD,     5'd13, 1'b1, 32'hABCD,     1'b0, 1'b0, 1'b1});
        vecs.push_back('{"bne_eq",    5'd12, 32'h7,         32'h7,        5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{"bgeu",      5'd16, 32'h1,         32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sll31",     5'd2,  32'h1,         32'h3F,       5'd14, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"illegal31", 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h0,       1'b0, 1'b1, 1'b0});

        // Reset dominates stall and flush.
        rst_n = 1'b0;
        drive(1'b1, 5'd0, 32'h11, 32'h22, 5'd3, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 32'h11, 32'h22, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check_all_zero("reset_state");
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].ctrl, vecs[i].src1, vecs[i].src2, vecs[i].rd, vecs[i].wb_en, 1'b0, 1'b0);
            tick();
            check({vecs[i].name, ".valid"},  64'(bus.out_valid),    64'd1);
            check({vecs[i].name, ".result"}, 64'(bus.out_result),   64'(vecs[i].exp_result));
            check({vecs[i].name, ".rd"},     64'(bus.out_rd),       64'(vecs[i].rd));
            check({vecs[i].name, ".wb_en"},  64'(bus.out_wb_en),    64'(vecs[i].exp_wb));
            check({vecs[i].name, ".br"},     64'(bus.out_br_taken), 64'(vecs[i].exp_br));
            check({vecs[i].name, ".ill"},    64'(bus.out_illegal),  64'(vecs[i].exp_ill));
        end

        // Invalid slot: flags forced low.
        drive(1'b0, 5'd10, 32'h1001, 32'h4, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check("bubble.valid", 64'(bus.out_valid),    64'd0);
        check("bubble.wb_en", 64'(bus.out_wb_en),    64'd0);
        check("bubble.br",    64'(bus.out_br_taken), 64'd0);

        // Stall holds for three cycles, then stall+flush inserts a bubble.
        drive(1'b1, 5'd0, 32'h1, 32'h2, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        check("hold_pre.result", 64'(bus.out_result), 64'd3);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd5, $urandom, $urandom, 5'd20, 1'b1, 1'b1, 1'b0);
            tick();
            check("hold.result", 64'(bus.out_result), 64'd3);
            check("hold.valid",  64'(bus.out_valid),  64'd1);
            check("hold.rd",     64'(bus.out_rd),     64'd8);
            check("hold.wb_en",  64'(bus.out_wb_en),  64'd1);
        end
        drive(1'b1, 5'd10, 32'h40, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1);
        tick();
        check("stall_flush.valid", 64'(bus.out_valid),    64'd0);
        check("stall_flush.wb_en", 64'(bus.out_wb_en),    64'd0);
        check("stall_flush.br",    64'(bus.out_br_taken), 64'd0);

        // Reset during a stall discards the held instruction.
        drive(1'b1, 5'd8, 32'hF0, 32'h0F, 5'd21, 1'b1, 1'b0, 1'b0);
        tick();
        check("pre_rst.result", 64'(bus.out_result), 64'hFF);
        drive(1'b1, 5'd8, 32'h1, 32'h2, 5'd22, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mid_stall");
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 32'hFF00, 32'h0FF0, 5'd23, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst.valid",  64'(bus.out_valid),  64'd1);
        check("post_rst.result", 64'(bus.out_result), 64'hF0F0);
        check("post_rst.rd",     64'(bus.out_rd),     64'd23);
        check("post_rst.wb_en",  64'(bus.out_wb_en),  64'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 31)), a, b, 5'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
            check_model("rand");
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
